// File: rtl/serial_adder_flags.sv
// Bit-serial two's-complement adder: one full-adder cell plus a carry flip-flop,
// LSB first, with a start/done handshake and N/Z/C/V status flags.
module serial_adder_flags #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] result,
    output logic         neg_flag,
    output logic         zr_flag,
    output logic         cry_flag,
    output logic         of_flag,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [N-1:0]   a_sr, b_sr;
    logic [N-2:0]   sum_sr;
    logic           carry;
    logic           a_msb, b_msb;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           last_bit;
    logic           sum_bit;
    logic           carry_next;
    logic [N-1:0]   sum_full;

    assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // The bit being processed now joins the previously shifted bits as the MSB.
    assign sum_full   = {sum_bit, sum_sr};
    assign last_bit   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            neg_flag <= 1'b0;
            zr_flag  <= 1'b0;
            cry_flag <= 1'b0;
            of_flag  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= cin;
            a_msb  <= a[N-1];
            b_msb  <= b[N-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_full[N-1:1];
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
            // Outputs change only on the final bit so partial sums never show.
            if (last_bit) begin
                result   <= sum_full;
                neg_flag <= sum_bit;
                zr_flag  <= (sum_full == '0);
                cry_flag <= carry_next;
                of_flag  <= (a_msb == b_msb) && (sum_bit != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_flags.sv
// Scoreboard bench for serial_adder_flags: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_serial_adder_flags;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic [N-1:0] result;
    logic         neg_flag, zr_flag, cry_flag, of_flag, busy, done;

    serial_adder_flags #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .result(result), .neg_flag(neg_flag), .zr_flag(zr_flag),
        .cry_flag(cry_flag), .of_flag(of_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] res;
        logic         neg, zr, cry, of;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    logic [N+3:0] last_out = '0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: integer arithmetic on the operand values, signed range for overflow.
    function automatic exp_t model(input int unsigned av, input int unsigned bv, input int unsigned cv);
        exp_t e;
        int unsigned u;
        int sa, sb, s;
        u  = av + bv + cv;
        sa = (av >= 2**(N-1)) ? int'(av) - 2**N : int'(av);
        sb = (bv >= 2**(N-1)) ? int'(bv) - 2**N : int'(bv);
        s  = sa + sb + int'(cv);
        e.res = N'(u % (2**N));
        e.cry = (u >= 2**N);
        e.zr  = ((u % (2**N)) == 0);
        e.neg = ((u % (2**N)) >= 2**(N-1));
        e.of  = (s > 2**(N-1) - 1) || (s < -(2**(N-1)));
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_out = '0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("neg_flag", neg_flag, e.neg);
                check("zr_flag", zr_flag, e.zr);
                check("cry_flag", cry_flag, e.cry);
                check("of_flag", of_flag, e.of);
                check("busy_in_done", busy, 0);
                check("done_latency_cycle", cyc, e.cyc);
            end
            last_out = {result, neg_flag, zr_flag, cry_flag, of_flag};
        end else begin
            check("hold_outputs", {result, neg_flag, zr_flag, cry_flag, of_flag}, last_out);
        end
    end

    // Caller is at a negedge; the following posedge accepts the start.
    task automatic do_op(input int unsigned av, input int unsigned bv, input int unsigned cv);
        exp_t e;
        a = N'(av); b = N'(bv); cin = cv[0]; start = 1'b1;
        e = model(av, bv, cv);
        e.cyc = cyc + 1 + N;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        check("busy_run", busy, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("done_timeout", seen, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_flags", {neg_flag, zr_flag, cry_flag, of_flag}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3, 4, 0);  wait_done();
        @(negedge clk);
        do_op(7, 1, 0);  wait_done();
        @(negedge clk);
        do_op(15, 1, 0); wait_done();
        @(negedge clk);
        do_op(8, 8, 1);  wait_done();
        do_op(2, 2, 0);  wait_done();   // issued in the DONE cycle
        @(negedge clk);

        do_op(5, 6, 0);
        @(negedge clk);
        check("busy_at_ignored_start", busy, 1);
        a = 1; b = 1; cin = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        do_op(3, 3, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_result", result, 0);
        check("abort_flags", {neg_flag, zr_flag, cry_flag, of_flag}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(9, 12, 1); wait_done();
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 2**N - 1), $urandom_range(0, 2**N - 1), $urandom_range(0, 1));
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
